// File: rtl/arbitrated_multiplexer.sv
// Arbitrated N-to-1 multiplexer with a registered, valid/ready output stage.
// Mode 0 picks the channel named by select; mode 1 round-robins among the
// valid channels, starting just after the last round-robin grant.
module arbitrated_multiplexer #(
  parameter int inputWidth  = 8,
  parameter int numInputs   = 4,
  parameter int selectLines = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [inputWidth*numInputs-1:0] inputBus,
  input  logic [numInputs-1:0]            inputValid,
  output logic [numInputs-1:0]            inputReady,
  input  logic                            mode,
  input  logic [selectLines-1:0]          select,
  output logic [inputWidth-1:0]           out,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [selectLines-1:0]          grant
);

  // Pointer value that makes the first round-robin search begin at channel 0
  localparam logic [selectLines-1:0] LAST_GRANT_RST = selectLines'(numInputs - 1);

  logic [inputWidth-1:0]  out_q, out_d;
  logic [selectLines-1:0] grant_q, grant_d;
  logic                   out_valid_q, out_valid_d;
  logic [selectLines-1:0] last_grant_q, last_grant_d;

  logic                   can_load;
  logic                   rr_found;
  logic [selectLines-1:0] rr_idx;
  int                     rr_best;
  int                     rr_dist;
  logic                   sel_ok;
  logic                   chosen_ok;
  logic [selectLines-1:0] chosen_idx;
  logic [inputWidth-1:0]  chosen_data;
  logic                   xfer;

  // Round-robin search: the valid channel closest above last_grant wins
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_best  = numInputs;
    rr_dist  = 0;
    for (int i = 0; i < numInputs; i++) begin
      rr_dist = (i + 2 * numInputs - int'(last_grant_q) - 1) % numInputs;
      if (inputValid[i] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_found = 1'b1;
        rr_idx   = i[selectLines-1:0];
      end
    end
  end

  // Direct-mode check: select must name an existing channel that holds data
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < numInputs; i++) begin
      if ((int'(select) == i) && inputValid[i]) sel_ok = 1'b1;
    end
  end

  // Choose channel, decide transfer and mux its data
  always_comb begin
    chosen_idx  = mode ? rr_idx : select;
    chosen_ok   = mode ? rr_found : sel_ok;
    can_load    = !out_valid_q || outReady;
    xfer        = !rst && can_load && chosen_ok;
    chosen_data = '0;
    for (int i = 0; i < numInputs; i++) begin
      if (int'(chosen_idx) == i) chosen_data = inputBus[i*inputWidth +: inputWidth];
    end
  end

  // One-hot consume strobe for the transferring channel only
  always_comb begin
    inputReady = '0;
    for (int i = 0; i < numInputs; i++) begin
      inputReady[i] = xfer && (int'(chosen_idx) == i);
    end
  end

  // Next state of the output register and round-robin pointer
  always_comb begin
    out_d        = out_q;
    grant_d      = grant_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (can_load) begin
      if (xfer) begin
        out_d       = chosen_data;
        grant_d     = chosen_idx;
        out_valid_d = 1'b1;
        if (mode) last_grant_d = chosen_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      grant_q      <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      out_q        <= out_d;
      grant_q      <= grant_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out      = out_q;
  assign grant    = grant_q;
  assign outValid = out_valid_q;

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Self-checking bench for arbitrated_multiplexer: directed scenarios followed
// by random traffic, all compared against a transaction-level reference model.
module tb_arbitrated_multiplexer;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W*N-1:0] inputBus;
  logic [N-1:0]   inputValid;
  logic [N-1:0]   inputReady;
  logic           mode;
  logic [S-1:0]   select;
  logic [W-1:0]   out;
  logic           outValid;
  logic           outReady;
  logic [S-1:0]   grant;

  arbitrated_multiplexer #(.inputWidth(W), .numInputs(N), .selectLines(S)) dut (
    .clk(clk), .rst(rst), .inputBus(inputBus), .inputValid(inputValid),
    .inputReady(inputReady), .mode(mode), .select(select), .out(out),
    .outValid(outValid), .outReady(outReady), .grant(grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_out   = 0;
  int m_grant = 0;
  int m_valid = 0;
  int m_last  = N - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Channel the arbitration rules pick this cycle, or -1 if none qualifies
  function automatic int pick();
    if (mode == 1'b0) begin
      if (int'(select) < N && inputValid[select]) return int'(select);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (inputValid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int chan_data(input int c);
    return int'(inputBus[c*W +: W]);
  endfunction

  task automatic drive(input logic r, input logic m, input int sel,
                       input logic [N-1:0] iv, input logic [W*N-1:0] bus, input logic ordy);
    rst        = r;
    mode       = m;
    select     = sel[S-1:0];
    inputValid = iv;
    inputBus   = bus;
    outReady   = ordy;
  endtask

  // One clock: check the combinational strobe, clock, update model, check registers
  task automatic step();
    int c;
    int exp_ready;
    bit can;
    #1;
    c   = pick();
    can = (m_valid == 0) || outReady;
    exp_ready = (!rst && can && c >= 0) ? (1 << c) : 0;
    check("inputReady", 32'(inputReady), 32'(exp_ready));
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_grant = 0; m_valid = 0; m_last = N - 1;
    end else if (can) begin
      if (c >= 0) begin
        m_out = chan_data(c); m_grant = c; m_valid = 1;
        if (mode) m_last = c;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check("out", 32'(out), 32'(m_out));
    check("grant", 32'(grant), 32'(m_grant));
    check("outValid", 32'(outValid), 32'(m_valid));
    @(negedge clk);
  endtask

  function automatic logic [W*N-1:0] rand_bus();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int exp_rr[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};

    drive(1'b1, 1'b0, 0, '0, '0, 1'b0);
    step();
    step();

    // Direct select of channel 2
    drive(1'b0, 1'b0, 2, 4'b0100, 32'h11A5_2233, 1'b1);
    #1;
    check("r29_ready_lit", 32'(inputReady), 32'h4);
    step();
    check("r29_out_lit", 32'(out), 32'hA5);
    check("r29_grant_lit", 32'(grant), 32'd2);

    // Round-robin with all channels valid: 0,1,2,3,0,1 back to back
    drive(1'b1, 1'b1, 0, 4'b1111, rand_bus(), 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 0, 4'b1111, rand_bus(), 1'b1);
      step();
      check("r30_grant_lit", 32'(grant), 32'(exp_rr[i]));
      check("r30_valid_lit", 32'(outValid), 32'd1);
    end

    // Backpressure for three cycles, then reload on the same edge
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 0, 4'b1111, rand_bus(), 1'b0);
      step();
      check("r31_grant_hold", 32'(grant), 32'd1);
    end
    drive(1'b0, 1'b1, 0, 4'b1111, rand_bus(), 1'b1);
    step();
    check("r31_reload_grant", 32'(grant), 32'd2);

    // Round-robin over sparse valids from reset pointer 3
    drive(1'b1, 1'b1, 0, 4'b1010, rand_bus(), 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 0, 4'b1010, rand_bus(), 1'b1);
      step();
      check("r32_grant_lit", 32'(grant), (i == 1) ? 32'd3 : 32'd1);
    end

    // Direct select of an idle channel: held word drains, then bubble
    drive(1'b0, 1'b0, 1, 4'b1101, rand_bus(), 1'b0);
    step();
    check("r33_hold_valid", 32'(outValid), 32'd1);
    drive(1'b0, 1'b0, 1, 4'b1101, rand_bus(), 1'b1);
    step();
    check("r33_drop_valid", 32'(outValid), 32'd0);

    // Reset mid-stream with data pending
    drive(1'b0, 1'b1, 0, 4'b1111, rand_bus(), 1'b0);
    step();
    drive(1'b1, 1'b1, 0, 4'b1111, rand_bus(), 1'b1);
    #1;
    check("r34_ready_in_rst", 32'(inputReady), 32'd0);
    step();
    check("r34_valid_lit", 32'(outValid), 32'd0);
    check("r34_out_lit", 32'(out), 32'd0);
    drive(1'b0, 1'b1, 0, 4'b1111, rand_bus(), 1'b1);
    step();
    check("r34_first_rr", 32'(grant), 32'd0);

    // Random traffic with occasional mode changes and resets
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, N - 1)), N'($urandom()), rand_bus(),
            $urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
